button_conditioner: RTL and testbench

- Sits directly upstream of the settings-menu and game FSMs. It converts the eight raw board buttons {Start, C, B, A, Right, Left, Down, Up} into clean signals for those FSMs.
- Each raw input is synchronised and debounced, then turned into a single-cycle press pulse.
- Direction buttons also get hold-to-autorepeat.
- The pulse bus is the `buttons` input of the downstream FSMs. Those FSMs advance on every enabled cycle, so each press must appear as exactly one cycle high.

---
 rtl/button_conditioner.sv | 139 +++++++++++++
 tb/tb_button_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button front end: synchronise, debounce, press pulse and autorepeat.
// Feeds the settings-menu and game FSM `buttons` inputs.
module button_conditioner #(
    parameter int                   N_BTN           = 8,
    parameter int                   DEBOUNCE_CYCLES = 250000,
    parameter int                   REPEAT_DELAY    = 25000000,
    parameter int                   REPEAT_RATE     = 5000000,
    parameter logic [N_BTN-1:0]     REPEAT_MASK     = 8'h0F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             any_press
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] RD_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RR_LAST = HW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] pulse_q;
    logic [N_BTN-1:0] pulse_d;
    logic [N_BTN-1:0] ev;
    logic             any_q;

    logic [DW-1:0] dcnt_q [N_BTN];
    logic [DW-1:0] dcnt_d [N_BTN];
    logic [HW-1:0] hc_q   [N_BTN];
    logic [HW-1:0] hc_d   [N_BTN];
    rpt_state_e    st_q   [N_BTN];
    rpt_state_e    st_d   [N_BTN];

    always_comb begin
        level_d = level_q;
        ev      = '0;
        for (int i = 0; i < N_BTN; i++) begin
            dcnt_d[i] = dcnt_q[i];
            hc_d[i]   = hc_q[i];
            st_d[i]   = st_q[i];

            if (sync2_q[i] == level_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DB_LAST) begin
                level_d[i] = sync2_q[i];
                dcnt_d[i]  = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            end

            ev[i] = level_d[i] & ~level_q[i];

            // A falling level wins over a repeat that lands on the same edge.
            if (REPEAT_MASK[i]) begin
                if (level_q[i] && !level_d[i]) begin
                    st_d[i] = IDLE;
                    hc_d[i] = '0;
                end else begin
                    case (st_q[i])
                        IDLE: begin
                            if (ev[i]) begin
                                st_d[i] = DELAY;
                                hc_d[i] = '0;
                            end
                        end
                        DELAY: begin
                            if (hc_q[i] == RD_LAST) begin
                                ev[i]   = 1'b1;
                                hc_d[i] = '0;
                                st_d[i] = REPEAT;
                            end else begin
                                hc_d[i] = hc_q[i] + HW'(1);
                            end
                        end
                        REPEAT: begin
                            if (hc_q[i] == RR_LAST) begin
                                ev[i]   = 1'b1;
                                hc_d[i] = '0;
                            end else begin
                                hc_d[i] = hc_q[i] + HW'(1);
                            end
                        end
                        default: begin
                            st_d[i] = IDLE;
                            hc_d[i] = '0;
                        end
                    endcase
                end
            end
        end
        pulse_d = en ? ev : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= '0;
                hc_q[i]   <= '0;
                st_q[i]   <= IDLE;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            any_q   <= |pulse_d;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                hc_q[i]   <= hc_d[i];
                st_q[i]   <= st_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign any_press = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
// Edge e is the e-th rising edge after raw inputs are applied.
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] btn_raw;
    logic [7:0] btn_level;
    logic [7:0] btn_pulse;
    logic       any_press;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .N_BTN          (8),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .REPEAT_MASK    (8'h0F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .any_press(any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst     = 1'b0;
        en      = 1'b1;
        btn_raw = 8'hFF;

        // Reset held with all buttons pressed
        #23;
        check("rst_level", btn_level, 8'h00);
        check("rst_pulse", btn_pulse, 8'h00);
        check("rst_any", {7'd0, any_press}, 8'h00);
        step();
        check("rst_level2", btn_level, 8'h00);
        rst = 1'b1;
        for (int e = 0; e < 7; e++) begin
            step();
            check($sformatf("rel_pulse e%0d", e), btn_pulse,
                  (e == 5) ? 8'hFF : 8'h00);
            check($sformatf("rel_level e%0d", e), btn_level,
                  (e >= 5) ? 8'hFF : 8'h00);
            check($sformatf("rel_any e%0d", e), {7'd0, any_press},
                  (e == 5) ? 8'h01 : 8'h00);
        end
        btn_raw = 8'h00;
        idle(12);
        check("rel_settle", btn_level, 8'h00);

        // Clean press of A: no autorepeat, release is silent
        btn_raw = 8'h10;
        for (int e = 0; e < 40; e++) begin
            step();
            check($sformatf("a_pulse e%0d", e), btn_pulse,
                  (e == 5) ? 8'h10 : 8'h00);
            check($sformatf("a_level e%0d", e), btn_level,
                  (e >= 5) ? 8'h10 : 8'h00);
        end
        btn_raw = 8'h00;
        for (int e = 0; e < 10; e++) begin
            step();
            check($sformatf("a_rel_pulse e%0d", e), btn_pulse, 8'h00);
            check($sformatf("a_rel_level e%0d", e), btn_level,
                  (e >= 5) ? 8'h00 : 8'h10);
        end

        // Glitchy Up: 3 high, 1 low, 3 high, then low
        for (int e = 0; e < 17; e++) begin
            btn_raw = (e < 3 || (e >= 4 && e < 7)) ? 8'h01 : 8'h00;
            step();
            check($sformatf("gl_level e%0d", e), btn_level, 8'h00);
            check($sformatf("gl_pulse e%0d", e), btn_pulse, 8'h00);
        end

        // Down held: raw low before edge 22 drops the level at edge 27,
        // the same edge a repeat would otherwise fire
        for (int e = 0; e < 35; e++) begin
            btn_raw = (e < 22) ? 8'h02 : 8'h00;
            step();
            check($sformatf("dn_pulse e%0d", e), btn_pulse,
                  (e == 5 || e == 15 || e == 18 || e == 21 || e == 24)
                  ? 8'h02 : 8'h00);
        end
        check("dn_level_off", btn_level, 8'h00);
        btn_raw = 8'h02;
        for (int e = 0; e < 17; e++) begin
            step();
            check($sformatf("dn2_pulse e%0d", e), btn_pulse,
                  (e == 5 || e == 15) ? 8'h02 : 8'h00);
        end
        btn_raw = 8'h00;
        idle(12);

        // B + Left together
        btn_raw = 8'h24;
        for (int e = 0; e < 7; e++) begin
            step();
            check($sformatf("bl_pulse e%0d", e), btn_pulse,
                  (e == 5) ? 8'h24 : 8'h00);
            check($sformatf("bl_any e%0d", e), {7'd0, any_press},
                  (e == 5) ? 8'h01 : 8'h00);
        end
        btn_raw = 8'h00;
        idle(12);

        // Same press with en low across the pulse edge
        en      = 1'b0;
        btn_raw = 8'h24;
        for (int e = 0; e < 14; e++) begin
            if (e == 8) en = 1'b1;
            step();
            check($sformatf("en_pulse e%0d", e), btn_pulse, 8'h00);
            check($sformatf("en_any e%0d", e), {7'd0, any_press}, 8'h00);
        end
        check("en_level", btn_level, 8'h24);
        btn_raw = 8'h00;
        idle(12);

        // Right into REPEAT, then asynchronous reset while held
        btn_raw = 8'h08;
        for (int e = 0; e < 22; e++) begin
            step();
            check($sformatf("rt_pulse e%0d", e), btn_pulse,
                  (e == 5 || e == 15 || e == 18 || e == 21) ? 8'h08 : 8'h00);
        end
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_level", btn_level, 8'h00);
        check("mid_rst_pulse", btn_pulse, 8'h00);
        check("mid_rst_any", {7'd0, any_press}, 8'h00);
        step();
        rst = 1'b1;
        for (int e = 0; e < 16; e++) begin
            step();
            check($sformatf("rt2_pulse e%0d", e), btn_pulse,
                  (e == 5 || e == 15) ? 8'h08 : 8'h00);
            check($sformatf("rt2_level e%0d", e), btn_level,
                  (e >= 5) ? 8'h08 : 8'h00);
        end
        btn_raw = 8'h00;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
